// File: rtl/wb_slv_pkg.sv
// Shared types and constants for the Wishbone memory slave.
// Queue entries are sized to the core bus widths.
package wb_slv_pkg;
  localparam int CORE_DATA_WIDTH = 32;
  localparam int CORE_ADDR_WIDTH = 32;
  localparam int L1_LINE_SIZE    = 128;
  localparam int WCNT_W          = 4;
  localparam int TR_CNT_MAX      = L1_LINE_SIZE / CORE_DATA_WIDTH;
  localparam int IDX_W           = CORE_ADDR_WIDTH - 2;

  typedef struct packed {
    logic                           we;
    logic [IDX_W-1:0]               idx;
    logic [CORE_DATA_WIDTH-1:0]     dat;
    logic [CORE_DATA_WIDTH/8-1:0]   sel;
    logic                           oor;
  } wb_req_t;
endpackage

// File: rtl/wb_req_fifo.sv
// Synchronous request queue; head is visible combinationally so the
// response engine can service it in the pop cycle.
module wb_req_fifo
  import wb_slv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  wb_req_t      din,
  output wb_req_t      head,
  output logic         full,
  output logic         empty,
  output logic [PW:0]  count
);
  wb_req_t         store [DEPTH];
  logic [PW-1:0]   wptr, rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk)
    if (push && !flush) store[wptr] <= din;

  assign head  = store[rptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone B4 pipelined slave backed by a word-addressed RAM, with an
// in-order request queue and a fixed number of wait states per response.
module wb_mem_slave
  import wb_slv_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int QDEPTH      = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_stall_o
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int QW = $clog2(QDEPTH);
  localparam logic [WCNT_W-1:0] RELOAD = WCNT_W'(WAIT_CYCLES);

  wb_req_t             req, head;
  logic                push, pop, flush, full, empty;
  logic [QW:0]         q_count;
  logic [WCNT_W-1:0]   wcnt;
  logic [AW-1:0]       ridx;
  logic [DATA_W-1:0]   mem [MEM_WORDS];
  logic                unused;

  // Dropping cyc aborts everything queued, including a head that is due now.
  assign flush      = ~wb_cyc_i;
  assign push       = wb_cyc_i & wb_stb_i & ~full;
  assign pop        = ~flush & ~empty & (wcnt == '0);
  assign wb_stall_o = full;
  assign ridx       = head.idx[AW-1:0];
  assign unused     = ^{wb_adr_i[1:0], head.idx[IDX_W-1:AW], q_count};

  always_comb begin
    req     = '0;
    req.we  = wb_we_i;
    req.idx = IDX_W'(wb_adr_i[AW+1:2]);
    req.dat = CORE_DATA_WIDTH'(wb_dat_i);
    req.sel = (CORE_DATA_WIDTH/8)'(wb_sel_i);
    req.oor = (wb_adr_i >= ADDR_W'(MEM_WORDS*4));
  end

  wb_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (req),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  always_ff @(posedge wb_clk_i)
    if (pop && head.we && !head.oor)
      for (int b = 0; b < DATA_W/8; b++)
        if (head.sel[b]) mem[ridx][8*b +: 8] <= head.dat[8*b +: 8];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      wcnt     <= RELOAD;
    end else begin
      wb_ack_o <= pop & ~head.oor;
      wb_err_o <= pop & head.oor;
      // Reads see all earlier writes: those were committed at earlier pops.
      if (pop && !head.oor && !head.we) wb_dat_o <= mem[ridx];
      if (flush || pop)
        wcnt <= RELOAD;
      else if (!empty && wcnt != '0)
        wcnt <= wcnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench: one slave with 2 wait states, one with none for burst throughput.
module tb_wb_mem_slave;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic cyc = 0, stb = 0, we = 0;
  logic [31:0] adr = 0, wdat = 0, rdat;
  logic [3:0]  sel = 0;
  logic ack, err, stall;

  logic cyc0 = 0, stb0 = 0, we0 = 0;
  logic [31:0] adr0 = 0, wdat0 = 0, rdat0;
  logic [3:0]  sel0 = 0;
  logic ack0, err0, stall0;

  int checks = 0, errors = 0, ncyc = 0;
  int ack_t[$], ack0_t[$];
  logic [31:0] dat0_q[$];
  bit stall_seen = 0, stall0_seen = 0, both_hi = 0;

  wb_mem_slave #(.WAIT_CYCLES(2), .QDEPTH(4), .MEM_WORDS(1024)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(rdat),
    .wb_ack_o(ack), .wb_err_o(err), .wb_stall_o(stall));

  wb_mem_slave #(.WAIT_CYCLES(0), .QDEPTH(4), .MEM_WORDS(1024)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_we_i(we0),
    .wb_adr_i(adr0), .wb_dat_i(wdat0), .wb_sel_i(sel0), .wb_dat_o(rdat0),
    .wb_ack_o(ack0), .wb_err_o(err0), .wb_stall_o(stall0));

  always @(posedge clk) ncyc++;

  always @(negedge clk) begin
    if (ack) ack_t.push_back(ncyc);
    if (ack0) begin
      ack0_t.push_back(ncyc);
      dat0_q.push_back(rdat0);
    end
    if (stall)  stall_seen  = 1;
    if (stall0) stall0_seen = 1;
    if ((ack & err) | (ack0 & err0)) both_hi = 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Isolated request; returns edges from accept to visible response.
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output int lat, output logic gerr);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk);
    #1 stb = 0;
    lat = -1; gerr = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack | err) begin
        lat = i; gerr = err;
        break;
      end
    end
    @(negedge clk);
    chk("resp_one_cycle", {30'd0, ack, err}, 32'd0);
  endtask

  int lat, t0;
  logic e;

  initial begin
    #3;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    // write then read, 2 wait states
    req(1, 32'h10, 32'hDEADBEEF, 4'hF, lat, e);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_err", {31'd0, e}, 32'd0);
    req(0, 32'h10, 32'h0, 4'hF, lat, e);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_dat", rdat, 32'hDEADBEEF);

    // byte enables
    req(1, 32'h20, 32'h11223344, 4'hF, lat, e);
    req(1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, e);
    req(0, 32'h20, 32'h0, 4'hF, lat, e);
    chk("sel_dat", rdat, 32'h11BB33DD);

    // out-of-range read terminates with err, data holds
    req(0, 32'h1000, 32'h0, 4'hF, lat, e);
    chk("oor_err", {31'd0, e}, 32'd1);
    chk("oor_lat", 32'(lat), 32'd3);
    chk("oor_dat_hold", rdat, 32'h11BB33DD);

    // six back-to-back writes; queue fills and stalls
    ack_t.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cyc = 1; stb = 1; we = 1; adr = 32'h100 + 32'(4*i); wdat = 32'hC0DE0000 + 32'(i); sel = 4'hF;
      for (int k = 0; k < 20 && stall; k++) @(negedge clk);
      @(posedge clk);
    end
    #1 stb = 0;
    repeat (25) @(negedge clk);
    chk("stall_seen", {31'd0, stall_seen}, 32'd1);
    chk("stall_acks", 32'(ack_t.size()), 32'd6);
    for (int i = 1; i < ack_t.size(); i++)
      chk("stall_spacing", 32'(ack_t[i] - ack_t[i-1]), 32'd3);
    req(0, 32'h100, 32'h0, 4'hF, lat, e);
    chk("stall_first", rdat, 32'hC0DE0000);
    req(0, 32'h114, 32'h0, 4'hF, lat, e);
    chk("stall_last", rdat, 32'hC0DE0005);

    // abort: three queued writes are dropped
    ack_t.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cyc = 1; stb = 1; we = 1; sel = 4'hF; wdat = 32'h0;
      adr = (i == 0) ? 32'h10 : (i == 1) ? 32'h20 : 32'h100;
      @(posedge clk);
    end
    #1 cyc = 0; stb = 0;
    repeat (10) @(negedge clk);
    chk("abort_no_resp", 32'(ack_t.size()), 32'd0);
    req(0, 32'h10, 32'h0, 4'hF, lat, e);
    chk("abort_keep_10", rdat, 32'hDEADBEEF);
    req(0, 32'h20, 32'h0, 4'hF, lat, e);
    chk("abort_keep_20", rdat, 32'h11BB33DD);
    req(0, 32'h100, 32'h0, 4'hF, lat, e);
    chk("abort_keep_100", rdat, 32'hC0DE0000);

    // async reset with a full queue and a loaded read register
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cyc = 1; stb = 1; we = 0; adr = 32'h10; sel = 4'hF;
      @(posedge clk);
    end
    @(negedge clk);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    chk("pre_rst_dat", rdat, 32'hDEADBEEF);
    cyc = 0; stb = 0;
    #2 rst = 1;
    #1;
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_ack", {31'd0, ack}, 32'd0);
    chk("arst_dat", rdat, 32'd0);
    @(negedge clk);
    rst = 0;
    req(0, 32'h10, 32'h0, 4'hF, lat, e);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_dat", rdat, 32'hDEADBEEF);

    // zero-wait line fill: 4 writes then 4 reads, all back-to-back
    @(negedge clk);
    t0 = ncyc;
    for (int i = 0; i < 8; i++) begin
      cyc0 = 1; stb0 = 1; we0 = (i < 4); sel0 = 4'hF;
      adr0 = 32'h40 + 32'(4*(i%4)); wdat0 = 32'hFACE0000 + 32'(i);
      @(posedge clk);
      #1;
    end
    stb0 = 0;
    repeat (6) @(negedge clk);
    chk("burst_no_stall", {31'd0, stall0_seen}, 32'd0);
    chk("burst_acks", 32'(ack0_t.size()), 32'd8);
    for (int i = 0; i < ack0_t.size(); i++)
      chk("burst_cycle", 32'(ack0_t[i]), 32'(t0 + 2 + i));
    for (int i = 4; i < dat0_q.size(); i++)
      chk("burst_data", dat0_q[i], 32'hFACE0000 + 32'(i-4));

    chk("ack_err_exclusive", {31'd0, both_hi}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
